// File: rtl/muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Optional macro MULDIV_EARLY_OUT_EN lets trivial operations bypass CALC.
module muldiv_seq #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            s_32,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [1:0]      state_dbg
);

    // Both handshakes are strict valid/ready: a transfer happens on a rising edge
    // where valid and ready are both high; kill blocks any transfer on that edge.
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [31:0] WORD_MIN = 32'h8000_0000;

    state_t            state;
    logic [2:0]        op_q;
    logic              word_q, neg_q, rneg_q, dz_q, ovf_q;
    logic [XLEN-1:0]   rs1_q, a_q, hi, lo, result_q;
    logic [6:0]        cnt;

    logic              word_in, signed_a, signed_b, sa, sb, is_div_in, dz_in, ovf_in;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_w, dividend_init;
    logic [6:0]        n_iter;

    always_comb begin
        word_in   = (XLEN == 64) && s_32;
        is_div_in = op[2];
        signed_a  = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
        signed_b  = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_ext = word_in ? (signed_a ? XLEN'(signed'(rs1[31:0])) : XLEN'(rs1[31:0])) : rs1;
        b_ext = word_in ? (signed_b ? XLEN'(signed'(rs2[31:0])) : XLEN'(rs2[31:0])) : rs2;
        sa    = signed_a & a_ext[XLEN-1];
        sb    = signed_b & b_ext[XLEN-1];
        a_mag = sa ? -a_ext : a_ext;
        b_mag = sb ? -b_ext : b_ext;
        min_w = word_in ? XLEN'(signed'(WORD_MIN)) : {1'b1, {(XLEN-1){1'b0}}};
        dz_in  = (b_ext == '0);
        ovf_in = ((op == 3'd4) || (op == 3'd6)) && (a_ext == min_w) && (b_ext == '1);
        n_iter = word_in ? 7'(32 / UNROLL) : 7'(XLEN / UNROLL);
        // A word dividend is pre-aligned to the top so MSB-first steps see it first.
        dividend_init = word_in ? (a_mag << (XLEN - 32)) : a_mag;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic early_in;
    always_comb begin
        early_in = dz_in | ovf_in | (a_ext == '0) |
                   (((op == 3'd5) || (op == 3'd7)) && (a_ext < b_ext));
    end
`endif

    logic [XLEN-1:0] n_hi, n_lo;
    logic [XLEN:0]   r, s;

    always_comb begin
        n_hi = hi;
        n_lo = lo;
        r    = '0;
        s    = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (op_q[2]) begin
                r    = {n_hi, n_lo[XLEN-1]};
                n_lo = {n_lo[XLEN-2:0], 1'b0};
                if (r >= {1'b0, a_q}) begin
                    r       = r - {1'b0, a_q};
                    n_lo[0] = 1'b1;
                end
                n_hi = r[XLEN-1:0];
            end else begin
                s    = {1'b0, n_hi} + (n_lo[0] ? {1'b0, a_q} : '0);
                n_lo = {s[0], n_lo[XLEN-1:1]};
                n_hi = s[XLEN:1];
            end
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, quo, rem, div_res, fix_res;

    always_comb begin
        // After W shift-add steps a word product sits XLEN-32 bits above its true position.
        prod = word_q ? ({hi, lo} >> (XLEN - 32)) : {hi, lo};
        if (neg_q) prod = -prod;
        if (word_q)              mul_res = XLEN'(signed'(prod[31:0]));
        else if (op_q == 3'd0)   mul_res = prod[XLEN-1:0];
        else                     mul_res = prod[2*XLEN-1:XLEN];
        quo = neg_q  ? -lo : lo;
        rem = rneg_q ? -hi : hi;
        if (dz_q) begin
            quo = '1;
            rem = rs1_q;
        end else if (ovf_q) begin
            quo = rs1_q;
            rem = '0;
        end
        div_res = op_q[1] ? rem : quo;
        if (word_q) div_res = XLEN'(signed'(div_res[31:0]));
        fix_res = op_q[2] ? div_res : mul_res;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            rs1_q    <= '0;
            a_q      <= '0;
            hi       <= '0;
            lo       <= '0;
            result_q <= '0;
            cnt      <= '0;
        end else if (kill) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q   <= op;
                    word_q <= word_in;
                    neg_q  <= sa ^ sb;
                    rneg_q <= sa;
                    dz_q   <= dz_in;
                    ovf_q  <= ovf_in;
                    rs1_q  <= a_ext;
                    a_q    <= is_div_in ? b_mag : a_mag;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_in) begin
                        // Quotient is zero, so the remainder is the dividend itself.
                        hi    <= is_div_in ? a_mag : '0;
                        lo    <= '0;
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        hi    <= '0;
                        lo    <= is_div_in ? dividend_init : b_mag;
                        cnt   <= n_iter;
                        state <= CALC;
                    end
`else
                    hi    <= '0;
                    lo    <= is_div_in ? dividend_init : b_mag;
                    cnt   <= n_iter;
                    state <= CALC;
`endif
                end
                CALC: begin
                    hi  <= n_hi;
                    lo  <= n_lo;
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) state <= FIX;
                end
                FIX: begin
                    result_q <= fix_res;
                    state    <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign state_dbg = state;

endmodule
